spi_rx_framer: RTL and testbench

SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

---
 rtl/spi_rx_framer.sv | 158 +++++++++++++++
 tb/tb_spi_rx_framer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_framer.sv
// SPI receive framer: SOF, LEN, payload, XOR checksum; good frames are replayed on a valid/ready port.
// Optional inter-byte timeout is enabled by defining SPI_RX_FRAMER_TIMEOUT_EN.
module spi_rx_framer #(
    parameter logic [7:0] SOF     = 8'h7E,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DRAIN} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("spi_rx_framer: MAX_LEN must be 1..16 and TIMEOUT >= 1");
    end

    state_t     state_q, state_d;
    logic [4:0] len_q, len_d;
    logic [7:0] chk_q, chk_d;
    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;
    logic       buf_we;
    logic       xfer;
    logic [7:0] buf_q [16];

`ifdef SPI_RX_FRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    // out_valid is held off during the frame_ok cycle so data follows the pulse
    assign out_valid = (state_q == S_DRAIN) && !ok_q;
    assign out_data  = out_valid ? buf_q[rd_ptr_q] : 8'h00;
    assign xfer      = out_valid && out_ready;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        chk_d    = chk_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        buf_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SOF) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_byte != 8'd0 && rx_byte <= MAX_LEN_B) begin
                        len_d    = rx_byte[4:0];
                        chk_d    = rx_byte;
                        wr_ptr_d = 4'd0;
                        state_d  = S_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 4'd1;
                    chk_d    = chk_q ^ rx_byte;
                    if ({1'b0, wr_ptr_q} == len_q - 5'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == chk_q) begin
                        ok_d     = 1'b1;
                        rd_ptr_d = 4'd0;
                        state_d  = S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_valid) ovr_d = 1'b1;
                if (xfer) begin
                    rd_ptr_d = rd_ptr_q + 4'd1;
                    if ({1'b0, rd_ptr_q} == len_q - 5'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SPI_RX_FRAMER_TIMEOUT_EN
        timer_d = '0;
        if (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM) begin
            if (!rx_valid) begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            chk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef SPI_RX_FRAMER_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
`ifdef SPI_RX_FRAMER_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // Payload storage carries no reset; reads are gated by state
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_ptr_q] <= rx_byte;
    end
endmodule

// File: tb/tb_spi_rx_framer.sv
// Randomized bench for spi_rx_framer: frame-level reference model plus payload scoreboard.
module tb_spi_rx_framer;
    localparam logic [7:0] SOF = 8'h7E;
    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       frame_ok, frame_err, overrun, busy;

    int total = 0, bad = 0;
    int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0;
    int exp_ok = 0, exp_err = 0;
    logic [7:0] exp_q[$];
    logic rand_rdy = 1'b0;
    logic force_rdy = 1'b1;

    spi_rx_framer #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1 out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end

    // Scoreboard: payload order and pulse accounting
    always @(negedge clk) begin
        if (rst) begin
            if (frame_ok) begin ok_cnt++; chk("ov_during_ok", {31'd0, out_valid}, 0); end
            if (frame_err) err_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_ok && frame_err) chk("ok_and_err", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", {24'd0, out_data}, 32'hFFFF);
                else chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Model: build frame from rules and record expected outcome
    task automatic send_frame(input logic [7:0] len, input logic [7:0] pay[$], input logic corrupt, input int gap);
        logic [7:0] cs;
        cs = len;
        send_byte(SOF); idle(gap);
        send_byte(len); idle(gap);
        if (len == 0 || len > MAX_LEN) begin
            exp_err++;
            return;
        end
        foreach (pay[i]) begin cs ^= pay[i]; send_byte(pay[i]); idle(gap); end
        if (corrupt) begin
            send_byte(cs ^ 8'(1 + $urandom_range(0, 254)));
            exp_err++;
        end else begin
            foreach (pay[i]) exp_q.push_back(pay[i]);
            send_byte(cs);
            exp_ok++;
        end
    endtask

    task automatic wait_idle_and_check(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) chk({tag, "_timeout"}, 1, 0);
        @(negedge clk); #1;
        chk({tag, "_ok"}, ok_cnt, exp_ok);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_drain"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] pay[$];
        int o0;
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ov", {31'd0, out_valid}, 0);
        chk("rst_od", {24'd0, out_data}, 0);
        chk("rst_pulses", {29'd0, frame_ok, frame_err, overrun}, 0);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Good frame with ready held high, then same with bad checksum
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, pay, 1'b0, 0);
        wait_idle_and_check("good3");
        chk("good3_busy", {31'd0, busy}, 0);
        send_byte(SOF); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h04); exp_err++;
        wait_idle_and_check("badcs");

        // Bad length bytes and ignored junk in IDLE
        pay = {};
        send_frame(8'h00, pay, 1'b0, 0);
        wait_idle_and_check("len0");
        send_frame(8'h11, pay, 1'b0, 0);
        wait_idle_and_check("len17");
        send_byte(8'h55); send_byte(8'h00);
        wait_idle_and_check("junk");

        // Backpressure with bytes arriving mid-drain
        force_rdy = 1'b0;
        o0 = ovr_cnt;
        pay = '{8'hA1, 8'hB2};
        send_frame(8'h02, pay, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 6) send_byte(8'($urandom)); else idle(1);
            @(negedge clk);
            if (i > 0) begin
                chk("hold_ov", {31'd0, out_valid}, 1);
                chk("hold_od", {24'd0, out_data}, 32'hA1);
            end
            @(posedge clk); #1;
        end
        chk("ovr_cnt", ovr_cnt - o0, 2);
        force_rdy = 1'b1;
        wait_idle_and_check("bp");

        // Stall in DATA
        send_byte(SOF); send_byte(8'h02); send_byte(8'hAA);
        idle(102);
        @(negedge clk); #1;
`ifdef SPI_RX_FRAMER_TIMEOUT_EN
        exp_err++;
        chk("to_err", err_cnt, exp_err);
        chk("to_busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
`else
        chk("to_err", err_cnt, exp_err);
        chk("to_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        send_byte(8'hBB); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB); exp_ok++;
`endif
        wait_idle_and_check("stall");

        // Reset in DATA
        send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b0; #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_out", {23'd0, out_valid, out_data}, 0);
        chk("mid_rst_pulses", {29'd0, frame_ok, frame_err, overrun}, 0);
        @(posedge clk); #1; rst = 1'b1;
        idle(3);
        pay = '{8'h7E, 8'h01};
        send_frame(8'h02, pay, 1'b0, 0);
        wait_idle_and_check("post_rst");

        // Random frames with random gaps and backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            logic [7:0] len;
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) send_byte(8'h00);
            pay = {};
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
            end else begin
                len = 8'($urandom_range(1, MAX_LEN));
                for (int k = 0; k < int'(len); k++)
                    pay.push_back(($urandom_range(0, 7) == 0) ? SOF : 8'($urandom));
            end
            send_frame(len, pay, kind == 1, $urandom_range(0, 3));
            wait_idle_and_check("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
